dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Two-port arbiter sharing the single data memory between the CPU load/store path and a host debug/loader port (driven from the TinyTapeout pins).
- Single request per cycle to memory, round-robin on conflict, optional host burst lock with a starvation bound.
- Routes the 1-cycle-latency synchronous read data back to the requester that issued the read.

Parameters:
- ADDR_W, 8, memory address width (256 words).
- DATA_W, 16, data word width.
- BURST_MAX, 4, max consecutive locked host grants while CPU is requesting; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- cpu_req  input  1  CPU access request.
- cpu_we  input  1  CPU write (1) / read (0).
- cpu_addr  input  ADDR_W  CPU word address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_gnt  output  1  CPU request accepted this cycle.
- cpu_stall  output  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  output  1  CPU read data valid on rdata.
- host_req  input  1  host access request.
- host_we  input  1  host write/read.
- host_addr  input  ADDR_W  host word address.
- host_wdata  input  DATA_W  host write data.
- host_lock  input  1  host requests burst priority.
- host_gnt  output  1  host request accepted this cycle.
- host_rvalid  output  1  host read data valid on rdata.
- rdata  output  DATA_W  read data (shared return bus).
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, registered by memory; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Handshake: requester holds req/we/addr/wdata stable until its gnt=1. gnt is combinational in the same cycle as accept. At most one gnt per cycle.
- Memory drive: mem_en = cpu_gnt | host_gnt. mem_we/addr/wdata are muxed from the granted port. When no grant, mem_we=0; addr and wdata hold the CPU values.
- Read return:
  - Registered rd_owner/rd_pending capture a granted read.
  - Next cycle, exactly one of cpu_rvalid/host_rvalid is 1, and rdata = mem_rdata.
  - Writes produce no rvalid.
  - Back-to-back reads give rvalid on consecutive cycles.
- Arbitration, per cycle:
  1. Only one req high: grant it.
  2. Both high, lock_active (host_lock=1 and burst_cnt < BURST_MAX): grant host.
  3. Both high otherwise: grant the port not in last_gnt.
- last_gnt register: updated on every grant.
- burst_cnt (4 bits):
  - Increments (saturating at BURST_MAX) on each host grant with host_lock=1 and cpu_req=1.
  - Cleared on any CPU grant, or when host_lock=0.
  - Unchanged on idle cycles.
- Starvation bound: with both requesting continuously under lock, the CPU waits at most BURST_MAX cycles.
- Reset values:
  - last_gnt=HOST, so the CPU wins the first conflict.
  - burst_cnt=0, rd_pending=0, rd_owner=CPU.
  - cpu_rvalid=host_rvalid=0.
  - While rst=1, gnts, mem_en and mem_we are forced to 0.
- Reset mid-operation: an outstanding read's rvalid is dropped and never delivered. A write granted in the cycle rst rises is not performed.
- Simultaneous host_lock rise with a pending CPU conflict: the lock takes effect in the same cycle (rule 2).
- cpu_stall is 0 whenever cpu_req=0.

Test Plan:
- Reset, then cpu_req read addr 3 alone (memory word 3 = 123) -> cpu_gnt=1 in cycle 0; cycle 1 cpu_rvalid=1, rdata=123, host_rvalid=0.
- Both req every cycle, host_lock=0, CPU reads addr 1,2 and host reads 10,11 -> grants alternate CPU,HOST,CPU,HOST; rvalids alternate one cycle later with matching data.
- host_lock=1, BURST_MAX=4, both req continuously -> host granted 4 cycles, CPU granted on the 5th, cpu_stall=1 for exactly 4 cycles.
- Host writes 0xBEEF to addr 54, then CPU reads 54 the next cycle -> mem_we pulse with addr 54; CPU rdata=0xBEEF one cycle after its grant.
- CPU read granted, rst asserted the following cycle -> cpu_rvalid stays 0, mem_en=0 during reset; after release the first conflict is granted to CPU.
- Host write with cpu_req=0 -> host_gnt=1, no rvalid asserted, cpu_stall=0 throughout.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one synchronous data memory between the CPU
// load/store path and the host debug/loader port. One access per cycle,
// round-robin on conflict, optional host burst lock bounded by BURST_MAX,
// and routing of 1-cycle-latency read data back to the issuing port.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic              host_lock,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {
      PORT_CPU  = 1'b0,
      PORT_HOST = 1'b1
   } port_e;

   localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

   port_e      last_gnt_q, last_gnt_d;
   port_e      rd_owner_q, rd_owner_d;
   logic       rd_pending_q, rd_pending_d;
   logic [3:0] burst_cnt_q, burst_cnt_d;
   logic       lock_active;

   // State register: last winner, burst counter and read-return tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_q   <= PORT_HOST;
         rd_owner_q   <= PORT_CPU;
         rd_pending_q <= 1'b0;
         burst_cnt_q  <= '0;
      end else begin
         last_gnt_q   <= last_gnt_d;
         rd_owner_q   <= rd_owner_d;
         rd_pending_q <= rd_pending_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   // Next-state: remember the winner, track the locked host burst and
   // capture which port a granted read belongs to.
   always_comb begin
      last_gnt_d   = last_gnt_q;
      rd_owner_d   = rd_owner_q;
      rd_pending_d = 1'b0;
      burst_cnt_d  = burst_cnt_q;

      if (cpu_gnt) begin
         last_gnt_d = PORT_CPU;
      end else if (host_gnt) begin
         last_gnt_d = PORT_HOST;
      end

      if (cpu_gnt || !host_lock) begin
         burst_cnt_d = '0;
      end else if (host_gnt && cpu_req && (burst_cnt_q < BURST_LIMIT)) begin
         burst_cnt_d = burst_cnt_q + 4'd1;
      end

      if ((cpu_gnt || host_gnt) && !mem_we) begin
         rd_pending_d = 1'b1;
         rd_owner_d   = host_gnt ? PORT_HOST : PORT_CPU;
      end
   end

   // Outputs: grant decision, memory mux and read-return steering.
   always_comb begin
      cpu_gnt     = 1'b0;
      host_gnt    = 1'b0;
      lock_active = host_lock && (burst_cnt_q < BURST_LIMIT);

      if (!rst) begin
         if (cpu_req && !host_req) begin
            cpu_gnt = 1'b1;
         end else if (host_req && !cpu_req) begin
            host_gnt = 1'b1;
         end else if (cpu_req && host_req) begin
            if (lock_active || (last_gnt_q == PORT_CPU)) begin
               host_gnt = 1'b1;
            end else begin
               cpu_gnt = 1'b1;
            end
         end
      end

      cpu_stall = cpu_req && !cpu_gnt;
      mem_en    = cpu_gnt || host_gnt;
      mem_we    = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (host_gnt) begin
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end else if (cpu_gnt) begin
         mem_we = cpu_we;
      end

      cpu_rvalid  = rd_pending_q && (rd_owner_q == PORT_CPU);
      host_rvalid = rd_pending_q && (rd_owner_q == PORT_HOST);
      rdata       = mem_rdata;
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, hand-written lock and
// reset sequences, then randomized traffic against a reference model.
module tb_dmem_port_arbiter;

   localparam int BMAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, host_req, host_we, host_lock;
   logic [7:0]  cpu_addr, host_addr, mem_addr;
   logic [15:0] cpu_wdata, host_wdata, mem_wdata, mem_rdata, rdata;
   logic        cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
   logic        mem_en, mem_we;

   logic [15:0] mem  [256];
   logic [15:0] mmem [256];

   int checks = 0;
   int errors = 0;

   dmem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .BURST_MAX(BMAX)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous memory with registered read data.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit creq, input bit cwe, input logic [7:0] caddr,
                        input logic [15:0] cwd, input bit hreq, input bit hwe,
                        input logic [7:0] haddr, input logic [15:0] hwd, input bit hlock);
      cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
      host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
      host_lock = hlock;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit creq; bit cwe; bit [7:0] caddr;
      bit hreq; bit hwe; bit [7:0] haddr; bit [15:0] hwd; bit hlock;
      bit cg; bit hg; bit crv; bit hrv; bit [15:0] rd;
      bit men; bit mwe; bit [7:0] maddr;
   } vec_t;

   vec_t vecs [9];

   // Reference-model state for the random phase
   bit          c_busy, c_we, h_busy, h_we, h_lock;
   logic [7:0]  c_addr, h_addr;
   logic [15:0] c_wd, h_wd;
   bit          cpu_won_last;
   int          host_streak;
   int          prv_owner;    // 0 none, 1 cpu, 2 host
   logic [15:0] prv_data;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
      mem[3] = 16'd123;

      vecs[0] = '{1,0,8'd3,  0,0,8'd0, 16'h0,0,    1,0,0,0,16'h0,     1,0,8'd3};
      vecs[1] = '{1,0,8'd1,  1,0,8'd10,16'h0,0,    0,1,1,0,16'd123,   1,0,8'd10};
      vecs[2] = '{1,0,8'd1,  1,0,8'd11,16'h0,0,    1,0,0,1,16'hA50A,  1,0,8'd1};
      vecs[3] = '{1,0,8'd2,  1,0,8'd11,16'h0,0,    0,1,1,0,16'hA501,  1,0,8'd11};
      vecs[4] = '{1,0,8'd2,  0,0,8'd0, 16'h0,0,    1,0,0,1,16'hA50B,  1,0,8'd2};
      vecs[5] = '{0,0,8'd2,  0,0,8'd0, 16'h0,0,    0,0,1,0,16'hA502,  0,0,8'd2};
      vecs[6] = '{0,0,8'd2,  1,1,8'd54,16'hBEEF,0, 0,1,0,0,16'h0,     1,1,8'd54};
      vecs[7] = '{1,0,8'd54, 0,0,8'd0, 16'h0,0,    1,0,0,0,16'h0,     1,0,8'd54};
      vecs[8] = '{0,0,8'd54, 0,0,8'd0, 16'h0,0,    0,0,1,0,16'hBEEF,  0,0,8'd54};

      // Reset: requests present but nothing may reach memory.
      rst = 1'b1;
      drive(1, 1, 8'd9, 16'h7777, 1, 1, 8'd9, 16'h8888, 0);
      @(negedge clk);
      check("rst_cpu_gnt", cpu_gnt, 0);
      check("rst_host_gnt", host_gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
      next_cycle();
      rst = 1'b0;
      drive(0, 0, 8'd0, 16'h5555, 0, 0, 8'd0, 16'h0, 0);

      // Directed vector table
      for (int v = 0; v < 9; v++) begin
         drive(vecs[v].creq, vecs[v].cwe, vecs[v].caddr, 16'h5555,
               vecs[v].hreq, vecs[v].hwe, vecs[v].haddr, vecs[v].hwd, vecs[v].hlock);
         @(negedge clk);
         check($sformatf("v%0d_cpu_gnt", v), cpu_gnt, vecs[v].cg);
         check($sformatf("v%0d_host_gnt", v), host_gnt, vecs[v].hg);
         check($sformatf("v%0d_cpu_stall", v), cpu_stall, vecs[v].creq & ~vecs[v].cg);
         check($sformatf("v%0d_cpu_rvalid", v), cpu_rvalid, vecs[v].crv);
         check($sformatf("v%0d_host_rvalid", v), host_rvalid, vecs[v].hrv);
         if (vecs[v].crv || vecs[v].hrv) check($sformatf("v%0d_rdata", v), rdata, vecs[v].rd);
         check($sformatf("v%0d_mem_en", v), mem_en, vecs[v].men);
         check($sformatf("v%0d_mem_we", v), mem_we, vecs[v].mwe);
         check($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].maddr);
         if (vecs[v].mwe) check($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].hwd);
         next_cycle();
      end

      // Locked host burst: host wins BMAX times, then the CPU gets through.
      begin
         int host_cnt = 0;
         int stall_cnt = 0;
         bit seen = 0;
         drive(1, 0, 8'd20, 16'h0, 1, 1, 8'd30, 16'h1234, 1);
         for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (host_gnt) host_cnt++;
            if (cpu_stall) stall_cnt++;
            if (cpu_gnt) seen = 1;
            next_cycle();
         end
         check("lock_cpu_gnt_seen", seen, 1);
         check("lock_host_grants", host_cnt, BMAX);
         check("lock_stall_cycles", stall_cnt, BMAX);
         drive(0, 0, 8'd20, 16'h0, 0, 0, 8'd0, 16'h0, 0);
         @(negedge clk);
         check("lock_cpu_rvalid", cpu_rvalid, 1);
         check("lock_rdata", rdata, 16'hA514);
         next_cycle();
      end

      // Reset while a CPU read is outstanding.
      drive(1, 0, 8'd5, 16'h0, 0, 0, 8'd0, 16'h0, 0);
      @(negedge clk);
      check("rmid_cpu_gnt", cpu_gnt, 1);
      next_cycle();
      rst = 1'b1;
      drive(1, 0, 8'd5, 16'h0, 1, 1, 8'd60, 16'h1111, 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("rmid_cpu_rvalid", cpu_rvalid, 0);
         check("rmid_mem_en", mem_en, 0);
         check("rmid_mem_we", mem_we, 0);
         check("rmid_gnts", {cpu_gnt, host_gnt}, 0);
         next_cycle();
      end
      rst = 1'b0;
      drive(1, 0, 8'd6, 16'h0, 1, 0, 8'd7, 16'h0, 0);
      @(negedge clk);
      check("rpost_cpu_gnt", cpu_gnt, 1);
      check("rpost_host_gnt", host_gnt, 0);
      check("rpost_no_stale_rvalid", cpu_rvalid, 0);
      next_cycle();
      drive(0, 0, 8'd6, 16'h0, 0, 0, 8'd7, 16'h0, 0);
      @(negedge clk);
      check("rpost_cpu_rvalid", cpu_rvalid, 1);
      check("rpost_rdata", rdata, 16'hA506);
      check("rpost_no_write_60", mem[60], 16'hA53C);
      next_cycle();

      // Randomized traffic against the reference model.
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      mmem = mem;
      c_busy = 0; h_busy = 0; h_lock = 0;
      c_we = 0; h_we = 0; c_addr = 0; h_addr = 0; c_wd = 0; h_wd = 0;
      cpu_won_last = 0; host_streak = 0; prv_owner = 0; prv_data = '0;
      for (int n = 0; n < 600; n++) begin
         bit ec, eh, both;
         if (!c_busy && $urandom_range(0, 2) != 0) begin
            c_busy = 1; c_we = 1'($urandom_range(0, 1));
            c_addr = 8'($urandom_range(0, 15)); c_wd = 16'($urandom);
         end
         if (!h_busy && $urandom_range(0, 2) != 0) begin
            h_busy = 1; h_we = 1'($urandom_range(0, 1));
            h_addr = 8'($urandom_range(0, 15)); h_wd = 16'($urandom);
         end
         if ($urandom_range(0, 5) == 0) h_lock = !h_lock;
         drive(c_busy, c_we, c_addr, c_wd, h_busy, h_we, h_addr, h_wd, h_lock);
         @(negedge clk);

         both = c_busy && h_busy;
         ec = 0; eh = 0;
         if (both) begin
            if ((h_lock && host_streak < BMAX) || cpu_won_last) eh = 1;
            else ec = 1;
         end else begin
            ec = c_busy;
            eh = h_busy;
         end

         check("rnd_cpu_gnt", cpu_gnt, ec);
         check("rnd_host_gnt", host_gnt, eh);
         check("rnd_cpu_stall", cpu_stall, c_busy && !ec);
         check("rnd_mem_en", mem_en, ec || eh);
         check("rnd_mem_we", mem_we, ec ? c_we : (eh ? h_we : 1'b0));
         check("rnd_mem_addr", mem_addr, eh ? h_addr : c_addr);
         check("rnd_cpu_rvalid", cpu_rvalid, prv_owner == 1);
         check("rnd_host_rvalid", host_rvalid, prv_owner == 2);
         if (prv_owner != 0) check("rnd_rdata", rdata, prv_data);

         prv_owner = 0;
         if (ec) begin
            if (c_we) mmem[c_addr] = c_wd;
            else begin prv_owner = 1; prv_data = mmem[c_addr]; end
            cpu_won_last = 1;
            c_busy = 0;
         end
         if (eh) begin
            if (h_we) mmem[h_addr] = h_wd;
            else begin prv_owner = 2; prv_data = mmem[h_addr]; end
            cpu_won_last = 0;
            h_busy = 0;
         end
         if (ec || !h_lock) host_streak = 0;
         else if (eh && both && host_streak < BMAX) host_streak++;
         next_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
